// File: rtl/tetris_pkg.sv
// Shared tetromino types, LFSR reset value and bag-generator FSM states.
// Also used by the colour lookup (piece_t).
package tetris_pkg;
  localparam int NUM_PIECES = 7;
  typedef logic [2:0] piece_t;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {S_CAND, S_PROBE, S_READY} bag_state_e;

  // Map a raw 3-bit draw onto 0..6.
  function automatic piece_t piece_fold(input logic [2:0] raw);
    return (raw == 3'd7) ? 3'd0 : raw;
  endfunction

  function automatic piece_t piece_wrap(input piece_t p);
    return (p == 3'd6) ? 3'd0 : p + 3'd1;
  endfunction
endpackage

// File: rtl/piece_bag_gen_if.sv
// Spawn-controller <-> piece generator handshake: seed control, request,
// current/preview pieces and their status flags.
interface piece_bag_gen_if;
  import tetris_pkg::*;
  logic [15:0] seed;
  logic        seed_load;
  logic        piece_req;
  piece_t      cur_piece;
  piece_t      next_piece;
  logic        piece_valid;
  logic        piece_ready;

  modport master (output seed, seed_load, piece_req,
                  input  cur_piece, next_piece, piece_valid, piece_ready);
  modport slave  (input  seed, seed_load, piece_req,
                  output cur_piece, next_piece, piece_valid, piece_ready);
endinterface

// File: rtl/piece_bag_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) free-running every cycle;
// a zero load value is replaced by LFSR_DEFAULT so the register never locks up.
module lfsr16
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);
  logic fb;
  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= LFSR_DEFAULT;
    else if (load) q <= (load_val == 16'h0000) ? LFSR_DEFAULT : load_val;
    else           q <= {q[14:0], fb};
  end
endmodule

// File: rtl/piece_bag_gen.sv
// Tetromino generator: LFSR draws into a cur/next slot pair; with PIECE_BAG7_EN
// defined, a used-mask enforces 7-bag fairness, otherwise each pick is a raw draw.
module piece_bag_gen
  import tetris_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  piece_bag_gen_if.slave bus
);
  logic [15:0] lfsr;
  bag_state_e  state_q;
  piece_t      cand_q, cur_q, next_q;
  logic        tgt_q, cur_vld_q, next_vld_q;
  logic        hit;

  lfsr16 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bus.seed_load),
    .load_val (bus.seed),
    .q        (lfsr)
  );

`ifdef PIECE_BAG7_EN
  logic [NUM_PIECES-1:0] used_q, used_d;
  assign hit = used_q[cand_q];

  // Completing a bag empties the mask in the same cycle as the last commit.
  always_comb begin
    used_d = used_q | (7'b1 << cand_q);
    if (&used_d) used_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               used_q <= '0;
    else if (bus.seed_load)                   used_q <= '0;
    else if (state_q == S_PROBE && !hit)      used_q <= used_d;
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CAND;
      cand_q     <= '0;
      cur_q      <= '0;
      next_q     <= '0;
      tgt_q      <= 1'b0;
      cur_vld_q  <= 1'b0;
      next_vld_q <= 1'b0;
    end else if (bus.seed_load) begin
      state_q    <= S_CAND;
      tgt_q      <= 1'b0;
      cur_vld_q  <= 1'b0;
      next_vld_q <= 1'b0;
    end else begin
      case (state_q)
        S_CAND: begin
          cand_q  <= piece_fold(lfsr[2:0]);
          state_q <= S_PROBE;
        end
        S_PROBE: begin
          if (hit) begin
            cand_q <= piece_wrap(cand_q);
          end else if (!tgt_q) begin
            cur_q     <= cand_q;
            cur_vld_q <= 1'b1;
            tgt_q     <= 1'b1;
            state_q   <= S_CAND;
          end else begin
            next_q     <= cand_q;
            next_vld_q <= 1'b1;
            state_q    <= S_READY;
          end
        end
        S_READY: begin
          // Shift preview into cur and refill only the preview slot.
          if (bus.piece_req) begin
            cur_q      <= next_q;
            next_vld_q <= 1'b0;
            tgt_q      <= 1'b1;
            state_q    <= S_CAND;
          end
        end
        default: state_q <= S_CAND;
      endcase
    end
  end

  assign bus.cur_piece   = cur_q;
  assign bus.next_piece  = next_q;
  assign bus.piece_valid = cur_vld_q;
  assign bus.piece_ready = cur_vld_q & next_vld_q;
endmodule

// File: tb/tb_piece_bag_gen.sv
// Bench for piece_bag_gen: behavioural model + accept scoreboard, table of seed runs,
// and hand-written corner sequences. Honours PIECE_BAG7_EN like the design.
module tb_piece_bag_gen;
  import tetris_pkg::*;

`ifdef PIECE_BAG7_EN
  localparam bit BAG = 1'b1;
  localparam int LAT = 8;
`else
  localparam bit BAG = 1'b0;
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piece_bag_gen_if bus();
  piece_bag_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model state
  logic [15:0] m_lfsr;
  int          m_st, m_cand, m_cur, m_next;
  bit          m_tgt, m_cv, m_nv;
  bit [6:0]    m_used;
  int          sb_q[$];

  typedef struct {
    logic [15:0] seed;
    int          nreq;
    int          gap;
  } vec_t;

  vec_t tbl[4];
  int   seq[4][21];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = LFSR_DEFAULT; m_st = 0; m_cand = 0; m_cur = 0; m_next = 0;
    m_tgt = 0; m_cv = 0; m_nv = 0; m_used = '0;
  endtask

  task automatic model_step();
    logic [15:0] l;
    l = m_lfsr;
    if (!rst_n) begin
      model_reset();
    end else if (bus.seed_load) begin
      m_lfsr = (bus.seed == 16'h0) ? LFSR_DEFAULT : bus.seed;
      m_used = '0; m_cv = 0; m_nv = 0; m_tgt = 0; m_st = 0;
    end else begin
      m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      case (m_st)
        0: begin m_cand = int'(l[2:0]) % 7; m_st = 1; end
        1: begin
          if (BAG && m_used[m_cand]) m_cand = (m_cand + 1) % 7;
          else begin
            if (!m_tgt) begin m_cur = m_cand; m_cv = 1; m_tgt = 1; m_st = 0; end
            else begin m_next = m_cand; m_nv = 1; m_st = 2; end
            if (BAG) begin
              m_used[m_cand] = 1'b1;
              if (m_used == 7'h7f) m_used = '0;
            end
          end
        end
        default: if (bus.piece_req) begin
          m_cur = m_next; m_nv = 0; m_tgt = 1; m_st = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    bit acc;
    int exp_cur;
    acc = rst_n && m_cv && m_nv && bus.piece_req && !bus.seed_load;
    exp_cur = m_next;
    @(posedge clk);
    model_step();
    if (acc) sb_q.push_back(exp_cur);
    #1;
    if (sb_q.size() > 0) check("accepted cur_piece", int'(bus.cur_piece), sb_q.pop_front());
    check("piece_ready", int'(bus.piece_ready), int'(m_cv && m_nv));
    check("piece_valid", int'(bus.piece_valid), int'(m_cv));
    if (m_nv) check("next_piece", int'(bus.next_piece), m_next);
  endtask

  task automatic wait_ready(input int max, input string name, output int n);
    n = 0;
    while (!bus.piece_ready && n < max) begin tick(); n++; end
    check(name, int'(bus.piece_ready), 1);
  endtask

  task automatic do_seed(input logic [15:0] s, input bit with_req);
    bus.seed = s; bus.seed_load = 1'b1; bus.piece_req = with_req;
    tick();
    bus.seed_load = 1'b0; bus.piece_req = 1'b0;
    check("valid low after seed", int'(bus.piece_valid), 0);
    check("ready low after seed", int'(bus.piece_ready), 0);
  endtask

  task automatic request(output int consumed);
    consumed = int'(bus.cur_piece);
    bus.piece_req = 1'b1;
    tick();
    bus.piece_req = 1'b0;
    check("ready low after accept", int'(bus.piece_ready), 0);
    check("valid held after accept", int'(bus.piece_valid), 1);
  endtask

  initial begin
    int n, p, c0, nx;
    int sa[7];
    int sb[7];
    bit [6:0] mask;

    tbl[0] = '{16'h0000, 14, 0};
    tbl[1] = '{16'hACE1, 14, 0};
    tbl[2] = '{16'h1234, 7, 3};
    tbl[3] = '{16'hBEEF, 21, 1};

    bus.seed = '0; bus.seed_load = 1'b0; bus.piece_req = 1'b0;
    model_reset();
    repeat (2) tick();
    check("reset cur_piece", int'(bus.cur_piece), 0);
    check("reset next_piece", int'(bus.next_piece), 0);
    check("reset piece_valid", int'(bus.piece_valid), 0);
    check("reset piece_ready", int'(bus.piece_ready), 0);
    rst_n = 1'b1;
    wait_ready(16, "ready after reset", n);
    check("cur range after reset", int'(bus.cur_piece < 3'd7), 1);
    check("next range after reset", int'(bus.next_piece < 3'd7), 1);

    for (int r = 0; r < 4; r++) begin
      do_seed(tbl[r].seed, 1'b0);
      wait_ready(16, "ready after seed", n);
      for (int k = 0; k < tbl[r].nreq; k++) begin
        request(p);
        seq[r][k] = p;
        check("consumed range", int'(p < 7), 1);
        wait_ready(LAT, "ready after accept", n);
        if (!BAG) check("pick latency", n, 2);
        repeat (tbl[r].gap) tick();
      end
      if (BAG) begin
        for (int b = 0; b + 7 <= tbl[r].nreq; b += 7) begin
          mask = '0;
          for (int k = 0; k < 7; k++) mask[seq[r][b + k]] = 1'b1;
          check("bag permutation", int'(mask), 32'h7f);
        end
      end
    end
    for (int k = 0; k < 14; k++) check("zero seed matches default", seq[0][k], seq[1][k]);

    // request while not ready is dropped; the next accepted one shifts once
    request(p);
    c0 = int'(bus.cur_piece);
    bus.piece_req = 1'b1; tick(); bus.piece_req = 1'b0;
    check("cur held on ignored req", int'(bus.cur_piece), c0);
    wait_ready(LAT, "ready after ignored req", n);
    nx = int'(bus.next_piece);
    request(p);
    check("single shift", int'(bus.cur_piece), nx);
    check("consumed is prior cur", p, c0);

    // seed_load wins over a simultaneous request and restarts the sequence
    wait_ready(LAT, "ready before restart", n);
    do_seed(16'h5A5A, 1'b0);
    wait_ready(16, "ready fresh seed", n);
    for (int k = 0; k < 7; k++) begin request(p); sa[k] = p; wait_ready(LAT, "ready fresh run", n); end
    do_seed(16'h5A5A, 1'b1);
    wait_ready(16, "ready collided seed", n);
    for (int k = 0; k < 7; k++) begin request(p); sb[k] = p; wait_ready(LAT, "ready collided run", n); end
    for (int k = 0; k < 7; k++) check("restart sequence", sb[k], sa[k]);

    // reset mid-pick leaves nothing committed
    do_seed(16'h0F0F, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midpick reset valid", int'(bus.piece_valid), 0);
    check("midpick reset ready", int'(bus.piece_ready), 0);
    check("midpick reset cur", int'(bus.cur_piece), 0);
    tick();
    rst_n = 1'b1;
    wait_ready(16, "ready after midpick reset", n);

`ifndef PIECE_BAG7_EN
    for (int k = 0; k < 1000; k++) begin
      request(p);
      check("cur never 7", int'(bus.cur_piece != 3'd7), 1);
      wait_ready(2, "ready bulk", n);
      check("bulk latency", n, 2);
      check("next never 7", int'(bus.next_piece != 3'd7), 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/piece_bag_gen.md
# piece_bag_gen

Generates the stream of tetromino IDs (0–6) consumed by the colour lookup and spawn logic. Uses a 16-bit LFSR with 7-bag fairness and holds a current piece and a one-deep preview (next) piece. The spawn controller takes a new piece through a ready/request handshake; `cur_piece` and `next_piece` feed the colour lookup for the playfield and preview renderers.

## Interface
- `LFSR_DEFAULT`, 16'hACE1: LFSR value after reset, and the substitute for a zero seed.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seed`  in  16: LFSR seed value.
- `seed_load`  in  1: one-cycle pulse; loads `seed` and restarts generation.
- `piece_req`  in  1: one-cycle pulse; consumes `cur_piece`.
- `cur_piece`  out  3: piece being spawned, range 0..6.
- `next_piece`  out  3: preview piece, range 0..6.
- `piece_valid`  out  1: `cur_piece` holds a committed piece.
- `piece_ready`  out  1: both slots valid; `piece_req` is accepted only while this is high.

## Operation
- LFSR: Fibonacci, taps 16,14,13,11, shifts every cycle in all states. A load of 16'h0000 stores `LFSR_DEFAULT`.
- `used[6:0]` marks the pieces already drawn from the current bag.
- `tgt` selects the slot to fill: 0 = cur, 1 = next.
- FSM states: S_CAND, S_PROBE, S_READY.
- **S_CAND:** `cand` = `lfsr[2:0]`, with 7 mapped to 0. Then go to S_PROBE.
- **S_PROBE:**
  - If `used[cand]` is set: `cand` = (`cand`==6) ? 0 : `cand`+1, and stay in S_PROBE.
  - Otherwise commit `cand` to the `tgt` slot and set `used[cand]`. If this makes `used` all ones, clear `used` to 0 in the same cycle.
  - After a commit to cur: `tgt`=1, go to S_CAND. After a commit to next: go to S_READY.
- **S_READY with `piece_req`:** `cur_piece` ← `next_piece`, next slot becomes invalid, `tgt`=1, go to S_CAND.
- `piece_req` while `piece_ready`=0 is ignored, with no state change.
- `seed_load` in any state: load the LFSR, clear `used`, invalidate both slots, set `tgt`=0, go to S_CAND. It takes priority over a simultaneous `piece_req`.
- `cur_piece` and `next_piece` are registered and never take the value 7.

## Timing
- Reset values: `cur_piece`=0, `next_piece`=0, `piece_valid`=0, `piece_ready`=0, `used`=0, state S_CAND, `tgt`=0, LFSR=`LFSR_DEFAULT`.
- A pick takes 2 cycles minimum (S_CAND plus committing S_PROBE). A full bag search takes at most 8 cycles (1 + 7 probes).
- From reset release or `seed_load` to `piece_ready`=1: at most 16 cycles.
- `piece_req` accepted at edge N:
  - New `cur_piece` is visible after edge N.
  - `piece_ready`=0 from edge N.
  - `piece_ready` returns to 1 within 8 cycles.
  - `piece_valid` stays 1 throughout.
- `seed_load` at edge N: `piece_valid`=0 and `piece_ready`=0 from edge N.
- Assertion of `rst_n` mid-pick aborts the pick immediately, with no partial commit.

## Configuration
- `PIECE_BAG7_EN` defined: 7-bag behaviour as above. Every aligned run of 7 consumed pieces since reset or seed load is a permutation of 0..6.
- `PIECE_BAG7_EN` undefined:
  - The `used` mask is removed and S_PROBE commits on its first cycle.
  - Each pick takes exactly 2 cycles; pieces are uniform over the LFSR mapping, with repeats allowed.
  - The interface is unchanged.

## Structure
- Shared package `tetris_pkg`:
  - `piece_t` (3-bit) and `NUM_PIECES`=7.
  - `LFSR_DEFAULT` value.
  - FSM state enum.
  - `piece_t` is shared with the colour lookup.
- Sub-module `lfsr16` (ports: `clk`, `rst_n`, `load`, `load_val`, `q`) holds the shift register and the zero-seed substitution.
- The FSM, slots and `used` mask stay in `piece_bag_gen`.

## Test plan
- Reset, hold requests low → `piece_ready` rises within 16 cycles; both outputs in 0..6.
- With `PIECE_BAG7_EN`: 14 requests, each issued when `piece_ready`=1 → pieces 1–7 and pieces 8–14 are each a permutation of {0..6}.
- `seed_load` with `seed`=16'h0000, then with 16'hACE1 → identical 14-piece sequences.
- `piece_req` pulsed while `piece_ready`=0 → `cur_piece` and `next_piece` unchanged; the next accepted request shifts exactly once.
- `seed_load` and `piece_req` in the same cycle → `piece_valid`=0 next cycle; sequence restarts as for a fresh seed.
- Without `PIECE_BAG7_EN`: 1000 requests → no value 7 on either output; each pick has 2-cycle latency.
